// File: rtl/decoder_onehot_reg.sv
// Registered IN_W-bit code decoder, one-hot or thermometer, with
// valid/ready handshake, 1-deep output register and error counter.
module decoder_onehot_reg #(
  parameter int IN_W       = 4,
  parameter int OUT_N      = 10,
  parameter int CNT_W      = 8,
  parameter int ACTIVE_LOW = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_code,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_N-1:0] y,
  output logic             err,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int KW = IN_W + 1;
  localparam logic POL = (ACTIVE_LOW != 0);
  localparam logic [OUT_N-1:0] Y_RST = {OUT_N{POL}};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             accept;
  logic             in_range;
  logic [OUT_N-1:0] dec;
  logic [OUT_N-1:0] y_d, y_q;
  logic             err_d, err_q;
  logic             ov_d, ov_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  assign in_ready = en & (~ov_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign in_range = {1'b0, in_code} < KW'(OUT_N);

  // Raw decode of the incoming code; thermometer sets every bit at or below c.
  always_comb begin
    dec = '0;
    for (int k = 0; k < OUT_N; k++) begin
      if (mode) dec[k] = ({1'b0, in_code} >= KW'(k));
      else      dec[k] = ({1'b0, in_code} == KW'(k));
    end
  end

  // Next-state for word register, valid flag and saturating error counter.
  always_comb begin
    y_d   = (in_range ? dec : '0) ^ {OUT_N{POL}};
    err_d = ~in_range;
    ov_d  = ov_q;
    if (accept)         ov_d = 1'b1;
    else if (out_ready) ov_d = 1'b0;
    cnt_d = cnt_q;
    if (clr_cnt)
      cnt_d = '0;
    else if (accept && !in_range && cnt_q != CNT_MAX)
      cnt_d = cnt_q + 1'b1;
  end

  // State registers; the word only loads on accept so it holds under stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ov_q  <= 1'b0;
      y_q   <= Y_RST;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      ov_q  <= ov_d;
      cnt_q <= cnt_d;
      if (accept) begin
        y_q   <= y_d;
        err_q <= err_d;
      end
    end
  end

  assign out_valid = ov_q;
  assign y         = y_q;
  assign err       = err_q;
  assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_decoder_onehot_reg.sv
// Scoreboard bench for decoder_onehot_reg: default, CNT_W=2 and
// ACTIVE_LOW=1 instances share one stimulus stream.
module tb_decoder_onehot_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_code = '0;
  logic       mode = 1'b0;
  logic       out_ready = 1'b1;
  logic       clr_cnt = 1'b0;

  logic       rdy1, rdy2, rdy3;
  logic       ov1, ov2, ov3;
  logic [9:0] y1, y2, y3;
  logic       e1, e2, e3;
  logic [7:0] c1, c3;
  logic [1:0] c2;

  decoder_onehot_reg dut1 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid),
    .in_ready(rdy1), .in_code(in_code), .mode(mode),
    .out_valid(ov1), .out_ready(out_ready), .y(y1), .err(e1),
    .clr_cnt(clr_cnt), .err_cnt(c1));

  decoder_onehot_reg #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid),
    .in_ready(rdy2), .in_code(in_code), .mode(mode),
    .out_valid(ov2), .out_ready(out_ready), .y(y2), .err(e2),
    .clr_cnt(clr_cnt), .err_cnt(c2));

  decoder_onehot_reg #(.ACTIVE_LOW(1)) dut3 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid),
    .in_ready(rdy3), .in_code(in_code), .mode(mode),
    .out_valid(ov3), .out_ready(out_ready), .y(y3), .err(e3),
    .clr_cnt(clr_cnt), .err_cnt(c3));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [10:0] q[$];
  bit  mon_en  = 1'b0;
  bit  exp_rdy = 1'b1;
  bit  pend    = 1'b0;
  bit  pend_n  = 1'b0;
  int  cnt     = 0;
  int  cnt_n   = 0;

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, a, e, $time);
    end
  endtask

  // {err, y} expected for a code, straight from the decode rules
  function automatic logic [10:0] model(int c, bit m);
    if (c >= 10) return {1'b1, 10'b0};
    if (!m) return {1'b0, 10'(1 << c)};
    return {1'b0, 10'((1 << (c + 1)) - 1)};
  endfunction

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  // One clock of stimulus; the model advances for the edge just passed.
  task automatic cyc(bit v, int code, bit m, bit ordy, bit e, bit clr);
    bit acc;
    @(posedge clk);
    #1;
    pend = pend_n;
    cnt  = cnt_n;
    in_valid  = v;
    in_code   = 4'(code);
    mode      = m;
    out_ready = ordy;
    en        = e;
    clr_cnt   = clr;
    exp_rdy = e & (!pend | ordy);
    acc = v & exp_rdy;
    if (acc) q.push_back(model(code, m));
    pend_n = acc ? 1'b1 : (ordy ? 1'b0 : pend);
    cnt_n  = clr ? 0 : cnt + ((acc && code >= 10) ? 1 : 0);
  endtask

  // Monitor: checks handshake, counters and the presented word.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [10:0] w;
      chk("in_ready", {31'b0, rdy1}, {31'b0, exp_rdy});
      chk("in_ready_al", {31'b0, rdy3}, {31'b0, exp_rdy});
      chk("out_valid", {31'b0, ov1}, {31'b0, pend});
      chk("out_valid_c2", {31'b0, ov2}, {31'b0, pend});
      chk("err_cnt", {24'b0, c1}, 32'(sat(cnt, 255)));
      chk("err_cnt_w2", {30'b0, c2}, 32'(sat(cnt, 3)));
      if (pend) begin
        if (q.size() == 0) begin
          chk("queue_nonempty", 32'd0, 32'd1);
        end else begin
          w = q[0];
          chk("y", {22'b0, y1}, {22'b0, w[9:0]});
          chk("err", {31'b0, e1}, {31'b0, w[10]});
          chk("y_active_low", {22'b0, y3}, {22'b0, ~w[9:0]});
          chk("err_active_low", {31'b0, e3}, {31'b0, w[10]});
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_out_valid", {31'b0, ov1}, 32'd0);
    chk("rst_y", {22'b0, y1}, 32'd0);
    chk("rst_err", {31'b0, e1}, 32'd0);
    chk("rst_cnt", {24'b0, c1}, 32'd0);
    chk("rst_y_active_low", {22'b0, y3}, 32'h3FF);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    for (int c = 0; c < 10; c++) cyc(1, c, 0, 1, 1, 0);
    cyc(1, 0, 1, 1, 1, 0);
    cyc(1, 5, 1, 1, 1, 0);
    cyc(1, 9, 1, 1, 1, 0);
    cyc(1, 10, 0, 1, 1, 0);
    cyc(1, 15, 1, 1, 1, 0);
    for (int i = 0; i < 5; i++) cyc(1, 11 + i % 5, i[0], 1, 1, 0);
    cyc(1, 12, 0, 1, 1, 1);
    cyc(0, 0, 0, 1, 1, 0);

    cyc(1, 7, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) cyc(1, 3, 0, 0, 1, 0);
    cyc(1, 3, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 1, 0);

    cyc(1, 4, 0, 1, 0, 0);
    cyc(1, 2, 0, 1, 0, 1);
    cyc(1, 2, 0, 1, 1, 0);
    cyc(1, 6, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);

    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 15),
          1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7,
          $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0);

    cyc(1, 4, 0, 1, 1, 0);
    cyc(1, 13, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    @(posedge clk);
    #2;
    chk("pre_rst_out_valid", {31'b0, ov1}, 32'd1);
    mon_en = 1'b0;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'b0, ov1}, 32'd0);
    chk("mid_rst_y", {22'b0, y1}, 32'd0);
    chk("mid_rst_err", {31'b0, e1}, 32'd0);
    chk("mid_rst_cnt", {24'b0, c1}, 32'd0);
    chk("mid_rst_cnt_w2", {30'b0, c2}, 32'd0);
    chk("mid_rst_y_active_low", {22'b0, y3}, 32'h3FF);
    q.delete();
    pend = 0; pend_n = 0; cnt = 0; cnt_n = 0;
    exp_rdy = en;
    @(negedge clk);
    rst = 1'b0;
    #1 mon_en = 1'b1;

    cyc(1, 2, 0, 1, 1, 0);
    cyc(1, 9, 1, 1, 1, 0);
    cyc(0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 1, 0);
    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
